// File: rtl/writeback_queue.sv
// writeback_queue: circular FIFO of pending register-bank writes.
// Results are accepted from upstream, drained to the register bank one per
// cycle unless the pipeline holds, and can be looked up for bypassing.
// Optional feature macro: WB_BYPASS_EN compiles in the bypass lookup
// comparators; without it the fwd_* outputs are tied to zero.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_reg,
    input  logic [31:0]                in_data,
    input  logic                       hold,
    output logic [4:0]                 write_reg,
    output logic                       write_enable,
    output logic [31:0]                write_data,
    input  logic [4:0]                 lookup_reg_1,
    input  logic [4:0]                 lookup_reg_2,
    output logic                       fwd_hit_1,
    output logic                       fwd_hit_2,
    output logic [31:0]                fwd_data_1,
    output logic [31:0]                fwd_data_2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    logic [4:0]    reg_mem_r  [DEPTH];
    logic [31:0]   data_mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic          push_s;
    logic          pop_s;

    assign count = count_r;

    // Handshake and drain control, all derived from registered state.
    always_comb begin
        in_ready     = !rst && (count_r != CNT_FULL);
        // Writes to register 0 complete the handshake but are never stored.
        push_s       = in_valid && in_ready && (in_reg != 5'd0);
        write_enable = (count_r != CNT_ZERO) && !hold && !rst;
        pop_s        = write_enable;
    end

    // Register bank write port: head entry while draining, zero otherwise.
    always_comb begin
        if (write_enable) begin
            write_reg  = reg_mem_r[head_r];
            write_data = data_mem_r[head_r];
        end else begin
            write_reg  = 5'd0;
            write_data = 32'd0;
        end
    end

    // Queue storage, pointers and occupancy; reset discards pending entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= AW'(1'b0);
            tail_r  <= AW'(1'b0);
            count_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                reg_mem_r[tail_r]  <= in_reg;
                data_mem_r[tail_r] <= in_data;
                tail_r             <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    // Bypass lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        logic [AW-1:0] idx;
        logic          valid;
        logic          match_1;
        logic          match_2;
        fwd_hit_1  = 1'b0;
        fwd_hit_2  = 1'b0;
        fwd_data_1 = 32'd0;
        fwd_data_2 = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx        = head_r + AW'(i);
            valid      = !rst && (CW'(i) < count_r);
            match_1    = valid && (lookup_reg_1 != 5'd0) && (reg_mem_r[idx] == lookup_reg_1);
            match_2    = valid && (lookup_reg_2 != 5'd0) && (reg_mem_r[idx] == lookup_reg_2);
            fwd_hit_1  = fwd_hit_1 | match_1;
            fwd_hit_2  = fwd_hit_2 | match_2;
            fwd_data_1 = match_1 ? data_mem_r[idx] : fwd_data_1;
            fwd_data_2 = match_2 ? data_mem_r[idx] : fwd_data_2;
        end
    end
`else
    // Bypass disabled: ports kept for a stable interface, outputs held low.
    assign fwd_hit_1  = 1'b0;
    assign fwd_hit_2  = 1'b0;
    assign fwd_data_1 = 32'd0;
    assign fwd_data_2 = 32'd0;

    logic unused_lookup_s;
    assign unused_lookup_s = ^{lookup_reg_1, lookup_reg_2};
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed stimulus with a write scoreboard.
// Expected writes are queued when a handshake is issued; a negedge monitor
// pops and compares whenever write_enable is presented.
module tb_writeback_queue;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        hold;
    logic [4:0]  write_reg;
    logic        write_enable;
    logic [31:0] write_data;
    logic [4:0]  lookup_reg_1;
    logic [4:0]  lookup_reg_2;
    logic        fwd_hit_1;
    logic        fwd_hit_2;
    logic [31:0] fwd_data_1;
    logic [31:0] fwd_data_2;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    logic        last_ready;
    logic [36:0] exp_q[$];
    logic [36:0] exp_e;

    writeback_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .hold(hold),
        .write_reg(write_reg), .write_enable(write_enable), .write_data(write_data),
        .lookup_reg_1(lookup_reg_1), .lookup_reg_2(lookup_reg_2),
        .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
        .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; presents one beat and records it if accepted.
    task automatic push(input logic [4:0] r, input logic [31:0] d);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        @(negedge clk);
        last_ready = in_ready;
        @(posedge clk);
        if (last_ready && r != 5'd0) exp_q.push_back({r, d});
        #1;
        in_valid = 1'b0;
        in_reg   = 5'd0;
        in_data  = 32'd0;
    endtask

    task automatic to_drive;
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every presented write must match the oldest expected one.
    always @(negedge clk) begin
        if (write_enable) begin
            total++;
            if (rst || exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got reg=%0d data=%0d expected no write", write_reg, write_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({write_reg, write_data} !== exp_e) begin
                    bad++;
                    $display("FAIL write_order: got reg=%0d data=%0d expected reg=%0d data=%0d",
                             write_reg, write_data, exp_e[36:32], exp_e[31:0]);
                end
            end
        end else if (write_reg !== 5'd0 || write_data !== 32'd0) begin
            total++;
            bad++;
            $display("FAIL idle_port: got reg=%0d data=%0d expected 0", write_reg, write_data);
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_reg = 5'd0; in_data = 32'd0; hold = 1'b0;
        lookup_reg_1 = 5'd2; lookup_reg_2 = 5'd5; last_ready = 1'b0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_fwd_hit", 32'(fwd_hit_1), 32'd0);
        check("rst_fwd_data", fwd_data_2, 32'd0);
        to_drive();
        rst = 1'b0;

        // Single write latency
        push(5'd2, 32'd69);
        @(negedge clk);
        check("lat_we", 32'(write_enable), 32'd1);
        check("lat_reg", 32'(write_reg), 32'd2);
        check("lat_data", write_data, 32'd69);
        check("lat_count", 32'(count), 32'd1);
        @(negedge clk);
        check("lat_count_after", 32'(count), 32'd0);
        check("lat_ready_after", 32'(in_ready), 32'd1);
        to_drive();

        // Fill under hold, then bypass lookups
        hold = 1'b1;
        push(5'd2, 32'd69);
        push(5'd2, 32'd420);
        push(5'd5, 32'd1234);
        push(5'd7, 32'd1);
        push(5'd8, 32'd5);
        check("full_push_refused", 32'(last_ready), 32'd0);
        lookup_reg_1 = 5'd2;
        lookup_reg_2 = 5'd5;
        #1;
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("fwd1_hit", 32'(fwd_hit_1), BYP ? 32'd1 : 32'd0);
        check("fwd1_youngest", fwd_data_1, BYP ? 32'd420 : 32'd0);
        check("fwd2_hit", 32'(fwd_hit_2), BYP ? 32'd1 : 32'd0);
        check("fwd2_data", fwd_data_2, BYP ? 32'd1234 : 32'd0);
        lookup_reg_2 = 5'd3;
        #1;
        check("fwd2_miss_hit", 32'(fwd_hit_2), 32'd0);
        check("fwd2_miss_data", fwd_data_2, 32'd0);

        // Release hold: four back-to-back writes in order
        lookup_reg_1 = 5'd7;
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_count", 32'(count), 32'(4 - i));
            check("drain_we", 32'(write_enable), 32'd1);
            if (i == 0) check("full_pop_ready", 32'(in_ready), 32'd0);
            if (i == 3) begin
                check("head_pop_hit", 32'(fwd_hit_1), BYP ? 32'd1 : 32'd0);
                check("head_pop_data", fwd_data_1, BYP ? 32'd1 : 32'd0);
            end
        end
        @(negedge clk);
        check("drained_count", 32'(count), 32'd0);
        check("drained_we", 32'(write_enable), 32'd0);
        check("drained_ready", 32'(in_ready), 32'd1);
        to_drive();

        // Register 0 is accepted but dropped
        lookup_reg_1 = 5'd0;
        push(5'd0, 32'd99);
        check("r0_handshake", 32'(last_ready), 32'd1);
        @(negedge clk);
        check("r0_count", 32'(count), 32'd0);
        check("r0_we", 32'(write_enable), 32'd0);
        check("r0_fwd_hit", 32'(fwd_hit_1), 32'd0);
        to_drive();

        // Reset mid-drain discards pending entries
        hold = 1'b1;
        lookup_reg_1 = 5'd5;
        push(5'd5, 32'd11);
        push(5'd9, 32'd22);
        push(5'd5, 32'd33);
        rst = 1'b1;
        hold = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_we", 32'(write_enable), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_reg", 32'(write_reg), 32'd0);
        check("mid_rst_fwd_hit", 32'(fwd_hit_1), 32'd0);
        check("mid_rst_fwd_data", fwd_data_1, 32'd0);
        to_drive();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_we", 32'(write_enable), 32'd0);
        to_drive();
        push(5'd5, 32'd7);
        @(negedge clk);
        check("post_rst_first_we", 32'(write_enable), 32'd1);
        check("post_rst_first_reg", 32'(write_reg), 32'd5);
        check("post_rst_first_data", write_data, 32'd7);
        to_drive();

        // Continuous streaming across pointer wrap
        for (int i = 0; i < 8; i++) begin
            push(5'(i + 1), 32'(100 + i));
            check("stream_accept", 32'(last_ready), 32'd1);
            check("stream_count_le1", 32'(count <= 3'd1), 32'd1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stream_count_end", 32'(count), 32'd0);
        check("stream_no_loss", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
